huffman_dc_dpcm_enc: RTL and testbench

//  Streaming JPEG DC encoder: per-component DPCM prediction, size category, magnitude bits and Annex K DC Huffman code (luma/chroma).

---
 rtl/huff_dc_pkg.sv | 58 +++++
 rtl/huff_dc_size_cat.sv | 27 ++
 rtl/huffman_dc_dpcm_enc.sv | 162 ++++++++++++++++
 tb/tb_huffman_dc_dpcm_enc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/huff_dc_pkg.sv
// rtl/huff_dc_pkg.sv - JPEG DC Huffman tables and size-category helper
package huff_dc_pkg;

    localparam int MAX_SIZE = 11;
    localparam int CODE_W   = 11;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [3:0]        len;
    } huff_entry_t;

    // Bit length of a non-negative magnitude; 0 for zero.
    function automatic logic [3:0] size_cat(input logic [CODE_W:0] abs_val);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i <= CODE_W; i++) begin
            if (abs_val[i]) s = 4'(i + 1);
        end
        return s;
    endfunction

    function automatic huff_entry_t dc_code(input logic is_luma, input logic [3:0] size);
        huff_entry_t e;
        if (is_luma) begin
            case (size)
                4'd0:    e = '{11'h000, 4'd2};
                4'd1:    e = '{11'h002, 4'd3};
                4'd2:    e = '{11'h003, 4'd3};
                4'd3:    e = '{11'h004, 4'd3};
                4'd4:    e = '{11'h005, 4'd3};
                4'd5:    e = '{11'h006, 4'd3};
                4'd6:    e = '{11'h00E, 4'd4};
                4'd7:    e = '{11'h01E, 4'd5};
                4'd8:    e = '{11'h03E, 4'd6};
                4'd9:    e = '{11'h07E, 4'd7};
                4'd10:   e = '{11'h0FE, 4'd8};
                default: e = '{11'h1FE, 4'd9};
            endcase
        end else begin
            case (size)
                4'd0:    e = '{11'h000, 4'd2};
                4'd1:    e = '{11'h001, 4'd2};
                4'd2:    e = '{11'h002, 4'd2};
                4'd3:    e = '{11'h006, 4'd3};
                4'd4:    e = '{11'h00E, 4'd4};
                4'd5:    e = '{11'h01E, 4'd5};
                4'd6:    e = '{11'h03E, 4'd6};
                4'd7:    e = '{11'h07E, 4'd7};
                4'd8:    e = '{11'h0FE, 4'd8};
                4'd9:    e = '{11'h1FE, 4'd9};
                4'd10:   e = '{11'h3FE, 4'd10};
                default: e = '{11'h7FE, 4'd11};
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/huff_dc_size_cat.sv
// rtl/huff_dc_size_cat.sv - DC difference to size category and magnitude bits
module huff_dc_size_cat
    import huff_dc_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic signed [DW-1:0] diff_i,
    output logic [3:0]           size_o,
    output logic [CODE_W-1:0]    mag_o
);

    logic [DW-1:0]        abs_val;
    logic signed [DW-1:0] ones_val;
    logic [CODE_W-1:0]    ones_ext;
    logic [CODE_W-1:0]    mask;

    // Negative differences are sent as the one's complement of |diff|, i.e. diff-1.
    always_comb begin
        abs_val  = diff_i[DW-1] ? DW'(-diff_i) : diff_i;
        ones_val = diff_i[DW-1] ? diff_i - DW'(1) : diff_i;
        size_o   = size_cat((CODE_W+1)'(abs_val));
        ones_ext = CODE_W'(ones_val);
        mask     = ~({CODE_W{1'b1}} << size_o);
        mag_o    = ones_ext & mask;
    end

endmodule

// File: rtl/huffman_dc_dpcm_enc.sv
// rtl/huffman_dc_dpcm_enc.sv - 3-stage JPEG DC DPCM + Huffman encoder; HUFF_DC_RESTART_EN adds restart intervals
module huffman_dc_dpcm_enc
    import huff_dc_pkg::*;
#(
    parameter int COEF_W = 11,
    parameter int NUM_CH = 3,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_dc,
    input  logic [CH_W-1:0]   in_comp,
    input  logic              in_is_luma,
`ifdef HUFF_DC_RESTART_EN
    input  logic [15:0]       restart_intv,
    input  logic              in_mcu_end,
    output logic              out_rst_mark,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [3:0]        out_code_len,
    output logic [CODE_W-1:0] out_mag,
    output logic [3:0]        out_size
);

    localparam int DW = COEF_W + 1;

    if (COEF_W > MAX_SIZE || COEF_W < 2) begin : g_bad_coef_w
        $error("huffman_dc_dpcm_enc: COEF_W must be in 2..11");
    end

    logic              en, accept, comp_ok, restart_hit;
    logic [COEF_W-1:0] pred_q [NUM_CH];
    logic [COEF_W-1:0] pred_rd;

    logic                 s1_valid_q, s1_luma_q;
    logic signed [DW-1:0] s1_diff_q, s1_diff_d;
    logic                 s2_valid_q, s2_luma_q;
    logic [3:0]           s2_size_q, size_w;
    logic [CODE_W-1:0]    s2_mag_q, mag_w;
    logic                 s3_valid_q;
    logic [CODE_W-1:0]    s3_code_q, s3_mag_q;
    logic [3:0]           s3_len_q, s3_size_q;
    huff_entry_t          code_w;

    // Whole pipeline moves as one unit; no skid buffer, so a stalled output blocks input.
    assign en       = ~s3_valid_q | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & en;
    assign comp_ok  = 32'(in_comp) < NUM_CH;

    always_comb begin
        pred_rd   = comp_ok ? pred_q[in_comp] : '0;
        s1_diff_d = signed'({in_dc[COEF_W-1], in_dc}) - signed'({pred_rd[COEF_W-1], pred_rd});
        code_w    = dc_code(s2_luma_q, s2_size_q);
    end

    always_ff @(posedge clk) begin
        if (rst || restart_hit) begin
            for (int i = 0; i < NUM_CH; i++) pred_q[i] <= '0;
        end else if (accept && comp_ok) begin
            pred_q[in_comp] <= in_dc;
        end
    end

`ifdef HUFF_DC_RESTART_EN
    logic [15:0] mcu_cnt_q, mcu_cnt_d;
    logic        rst_pend_q, rst_pend_d;
    logic        s1_mark_q, s2_mark_q, s3_mark_q;

    always_comb begin
        mcu_cnt_d   = mcu_cnt_q;
        rst_pend_d  = rst_pend_q;
        restart_hit = 1'b0;
        if (accept) begin
            rst_pend_d = 1'b0;
            if (in_mcu_end) begin
                mcu_cnt_d = mcu_cnt_q + 16'd1;
                if (restart_intv != 16'd0 && mcu_cnt_d == restart_intv) begin
                    restart_hit = 1'b1;
                    mcu_cnt_d   = '0;
                    rst_pend_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcu_cnt_q  <= '0;
            rst_pend_q <= 1'b0;
            s1_mark_q  <= 1'b0;
            s2_mark_q  <= 1'b0;
            s3_mark_q  <= 1'b0;
        end else begin
            mcu_cnt_q  <= mcu_cnt_d;
            rst_pend_q <= rst_pend_d;
            if (en) begin
                s1_mark_q <= accept & rst_pend_q;
                s2_mark_q <= s1_mark_q;
                s3_mark_q <= s2_mark_q;
            end
        end
    end

    assign out_rst_mark = s3_mark_q;
`else
    assign restart_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_luma_q  <= 1'b0;
            s1_diff_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_luma_q  <= 1'b0;
            s2_size_q  <= '0;
            s2_mag_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_code_q  <= '0;
            s3_len_q   <= '0;
            s3_mag_q   <= '0;
            s3_size_q  <= '0;
        end else if (en) begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            if (accept) begin
                s1_diff_q <= s1_diff_d;
                s1_luma_q <= in_is_luma;
            end
            if (s1_valid_q) begin
                s2_size_q <= size_w;
                s2_mag_q  <= mag_w;
                s2_luma_q <= s1_luma_q;
            end
            if (s2_valid_q) begin
                s3_code_q <= code_w.code;
                s3_len_q  <= code_w.len;
                s3_mag_q  <= s2_mag_q;
                s3_size_q <= s2_size_q;
            end
        end
    end

    huff_dc_size_cat #(.DW(DW)) u_size_cat (
        .diff_i (s1_diff_q),
        .size_o (size_w),
        .mag_o  (mag_w)
    );

    assign out_valid    = s3_valid_q;
    assign out_code     = s3_code_q;
    assign out_code_len = s3_len_q;
    assign out_mag      = s3_mag_q;
    assign out_size     = s3_size_q;

endmodule

// File: tb/tb_huffman_dc_dpcm_enc.sv
// tb/tb_huffman_dc_dpcm_enc.sv - directed vector bench for huffman_dc_dpcm_enc
module tb_huffman_dc_dpcm_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_dc;
    logic [1:0]  in_comp;
    logic        in_is_luma;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_code;
    logic [3:0]  out_code_len;
    logic [10:0] out_mag;
    logic [3:0]  out_size;
`ifdef HUFF_DC_RESTART_EN
    logic [15:0] restart_intv;
    logic        in_mcu_end;
    logic        out_rst_mark;
`endif

    huffman_dc_dpcm_enc #(.COEF_W(11), .NUM_CH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dc        (in_dc),
        .in_comp      (in_comp),
        .in_is_luma   (in_is_luma),
`ifdef HUFF_DC_RESTART_EN
        .restart_intv (restart_intv),
        .in_mcu_end   (in_mcu_end),
        .out_rst_mark (out_rst_mark),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_code     (out_code),
        .out_code_len (out_code_len),
        .out_mag      (out_mag),
        .out_size     (out_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        int comp;
        int dc;
        bit luma;
        int code;
        int len;
        int size;
        int mag;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int bit_len(input int v);
        int s = 0;
        while ((1 << s) <= v) s++;
        return s;
    endfunction

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        in_comp    = 2'(v.comp);
        in_dc      = 11'(v.dc);
        in_is_luma = v.luma;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, q, held, held_mag;
        int dcs [8];

        vecs[0]  = '{0,     5, 1'b1, 'h004,  3,  3, 'h005};
        vecs[1]  = '{0,     2, 1'b1, 'h003,  3,  2, 'h000};
        vecs[2]  = '{1,     0, 1'b0, 'h000,  2,  0, 'h000};
        vecs[3]  = '{1, -1024, 1'b0, 'h7FE, 11, 11, 'h3FF};
        vecs[4]  = '{1,  1023, 1'b0, 'h7FE, 11, 11, 'h7FF};
        vecs[5]  = '{2,    -1, 1'b1, 'h002,  3,  1, 'h000};
        vecs[6]  = '{0,     2, 1'b1, 'h000,  2,  0, 'h000};
        vecs[7]  = '{2,     7, 1'b1, 'h005,  3,  4, 'h008};
        vecs[8]  = '{1,  1000, 1'b0, 'h01E,  5,  5, 'h008};
        vecs[9]  = '{3,   100, 1'b1, 'h01E,  5,  7, 'h064};
        vecs[10] = '{0, -1024, 1'b1, 'h1FE,  9, 11, 'h3FD};
        vecs[11] = '{0,  1023, 1'b1, 'h1FE,  9, 11, 'h7FF};
        vecs[12] = '{2,     9, 1'b0, 'h002,  2,  2, 'h002};
        vecs[13] = '{0,  1022, 1'b0, 'h001,  2,  1, 'h000};
        vecs[14] = '{2,    50, 1'b1, 'h00E,  4,  6, 'h029};
        vecs[15] = '{3,   100, 1'b1, 'h01E,  5,  7, 'h064};
        vecs[16] = '{1,  1004, 1'b0, 'h006,  3,  3, 'h004};

        rst = 1'b1; in_valid = 1'b0; in_dc = '0; in_comp = '0; in_is_luma = 1'b0; out_ready = 1'b1;
`ifdef HUFF_DC_RESTART_EN
        restart_intv = '0; in_mcu_end = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_code", out_code, 0);
        chk("reset_out_len", out_code_len, 0);
        chk("reset_out_mag", out_mag, 0);
        chk("reset_out_size", out_size, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1);

        // Table: one block per cycle, each result appears 3 edges after acceptance.
        drive(vecs[0]);
        for (int j = 1; j <= NV + 2; j++) begin
            @(posedge clk); #1;
            if (j >= 3) begin
                chk($sformatf("vec%0d_valid", j-3), out_valid, 1);
                chk($sformatf("vec%0d_code", j-3), out_code, vecs[j-3].code);
                chk($sformatf("vec%0d_len", j-3), out_code_len, vecs[j-3].len);
                chk($sformatf("vec%0d_size", j-3), out_size, vecs[j-3].size);
                chk($sformatf("vec%0d_mag", j-3), out_mag, vecs[j-3].mag);
            end else begin
                chk($sformatf("latency_idle%0d", j), out_valid, 0);
            end
            if (j < NV) drive(vecs[j]);
            else in_valid = 1'b0;
        end

        // Reset with blocks in flight: nothing may leak out afterwards.
        in_valid = 1'b1; in_comp = 2'd0; in_is_luma = 1'b1; in_dc = 11'd100;
        @(posedge clk); #1;
        in_dc = 11'd200;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_mag", out_mag, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_partial", out_valid, 0);
        end

        // Streaming with a 4-cycle output stall; predictor restarts from 0 after reset.
        for (int k = 0; k < 8; k++) dcs[k] = (k + 1) * (k + 2) / 2;
        p = 0; q = 0; held = 0; held_mag = 0;
        for (int cyc = 0; cyc < 60 && q < 8; cyc++) begin
            out_ready  = !(cyc >= 5 && cyc < 9);
            in_valid   = (p < 8);
            in_comp    = 2'd0;
            in_is_luma = 1'b1;
            in_dc      = (p < 8) ? 11'(dcs[p]) : 11'd0;
            @(negedge clk);
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (held != 0) chk("stall_hold_mag", out_mag, held_mag);
                held = 1; held_mag = out_mag;
            end else begin
                held = 0;
            end
            if (out_valid && out_ready) begin
                chk("stream_mag", out_mag, q + 1);
                chk("stream_size", out_size, bit_len(q + 1));
                q++;
            end
            if (in_valid && in_ready) p++;
            @(posedge clk); #1;
        end
        chk("stream_count", q, 8);
        chk("stream_accepted", p, 8);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_no_dup", out_valid, 0);
        end

`ifdef HUFF_DC_RESTART_EN
        begin
            int emag [7];
            emag = '{10, 20, 30, 30, 30, 30, 70};
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; restart_intv = 16'd2;
            q = 0;
            for (int j = 0; j < 12 && q < 7; j++) begin
                in_valid = (j < 7); in_comp = 2'(j % 3); in_is_luma = 1'b1;
                in_dc = 11'(10 * (j + 1)); in_mcu_end = (j % 3 == 2);
                @(negedge clk);
                if (out_valid) begin
                    chk($sformatf("restart_mag%0d", q), out_mag, emag[q]);
                    chk($sformatf("restart_mark%0d", q), out_rst_mark, (q == 6) ? 1 : 0);
                    q++;
                end
                @(posedge clk); #1;
            end
            chk("restart_count", q, 7);
            in_valid = 1'b0; in_mcu_end = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
